// File: rtl/r5p_gpio_ctrl.sv
// GPIO controller for the R5P system bus: output/enable registers with set/clear
// aliases, prescaled input debounce and sticky edge-capture status driving a level irq.
module r5p_gpio_ctrl #(
    parameter int unsigned GW    = 32,
    parameter int unsigned AW    = 6,
    parameter int unsigned DEB_N = 3,
    parameter int unsigned DIV_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bus_vld,
    output logic          bus_rdy,
    input  logic          bus_wen,
    input  logic [AW-1:0] bus_adr,
    input  logic [3:0]    bus_ben,
    input  logic [31:0]   bus_wdt,
    output logic [31:0]   bus_rdt,
    output logic          bus_err,
    output logic [GW-1:0] gpio_o,
    output logic [GW-1:0] gpio_e,
    input  logic [GW-1:0] gpio_i,
    output logic          irq
);

    typedef enum logic [3:0] {
        REG_OUT  = 4'h0,
        REG_OE   = 4'h1,
        REG_IN   = 4'h2,
        REG_SET  = 4'h3,
        REG_CLR  = 4'h4,
        REG_RISE = 4'h5,
        REG_FALL = 4'h6,
        REG_STAT = 4'h7,
        REG_DIV  = 4'h8
    } reg_e;

    localparam logic [AW-3:0] LAST_IDX = (AW-2)'(4'h8);

    logic [GW-1:0]    out_q, out_d;
    logic [GW-1:0]    oe_q, oe_d;
    logic [GW-1:0]    ren_q, ren_d;
    logic [GW-1:0]    fen_q, fen_d;
    logic [GW-1:0]    stat_q, stat_d;
    logic [GW-1:0]    in_q, in_d;
    logic [DEB_N-1:0] hist_q [GW];
    logic [DEB_N-1:0] hist_d [GW];
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdt_q, rdt_d;
    logic             err_q, err_d;
    logic             irq_q, irq_d;

    logic [AW-3:0]    widx;
    logic             hit;
    reg_e             sel;
    logic [31:0]      bmask;
    logic [GW-1:0]    wm;
    logic [GW-1:0]    wdat;
    logic [DIV_W-1:0] dm;
    logic [GW-1:0]    stat_clr;
    logic             div_wr;
    logic             tick;
    logic [GW-1:0]    rise_ev, fall_ev;
    logic             unused_bits;

    assign unused_bits = ^{bus_adr[1:0], bus_wdt};

    assign widx  = bus_adr[AW-1:2];
    assign hit   = (widx <= LAST_IDX);
    assign sel   = reg_e'(widx[3:0]);
    assign bmask = {{8{bus_ben[3]}}, {8{bus_ben[2]}}, {8{bus_ben[1]}}, {8{bus_ben[0]}}};
    assign wm    = bmask[GW-1:0];
    assign wdat  = bus_wdt[GW-1:0];
    assign dm    = bmask[DIV_W-1:0];

    // Bus decode: writes update registers at the transfer edge, reads sample pre-update values.
    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        ren_d    = ren_q;
        fen_d    = fen_q;
        div_d    = div_q;
        stat_clr = '0;
        div_wr   = 1'b0;
        err_d    = 1'b0;
        rdt_d    = '0;
        if (bus_vld) begin
            if (!hit) begin
                err_d = 1'b1;
            end else if (bus_wen) begin
                case (sel)
                    REG_OUT:  out_d    = (out_q & ~wm) | (wdat & wm);
                    REG_OE:   oe_d     = (oe_q & ~wm) | (wdat & wm);
                    REG_IN:   err_d    = 1'b1;
                    REG_SET:  out_d    = out_q | (wdat & wm);
                    REG_CLR:  out_d    = out_q & ~(wdat & wm);
                    REG_RISE: ren_d    = (ren_q & ~wm) | (wdat & wm);
                    REG_FALL: fen_d    = (fen_q & ~wm) | (wdat & wm);
                    REG_STAT: stat_clr = wdat & wm;
                    REG_DIV: begin
                        div_d  = (div_q & ~dm) | (bus_wdt[DIV_W-1:0] & dm);
                        div_wr = 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                case (sel)
                    REG_OUT:  rdt_d = 32'(out_q);
                    REG_OE:   rdt_d = 32'(oe_q);
                    REG_IN:   rdt_d = 32'(in_q);
                    REG_RISE: rdt_d = 32'(ren_q);
                    REG_FALL: rdt_d = 32'(fen_q);
                    REG_STAT: rdt_d = 32'(stat_q);
                    REG_DIV:  rdt_d = 32'(div_q);
                    default:  rdt_d = '0;
                endcase
            end
        end
    end

    assign tick = (cnt_q == div_q);

    always_comb begin
        if (div_wr || tick) cnt_d = '0;
        else                cnt_d = cnt_q + DIV_W'(1);
    end

    // The new sample joins the history before the all-equal test, so IN moves on the
    // same tick that completes DEB_N matching samples.
    always_comb begin
        in_d = in_q;
        for (int unsigned i = 0; i < GW; i++) begin
            hist_d[i] = hist_q[i];
            if (tick) begin
                hist_d[i] = {hist_q[i][DEB_N-2:0], gpio_i[i]};
                if ((&hist_d[i]) && !in_q[i])       in_d[i] = 1'b1;
                else if (!(|hist_d[i]) && in_q[i])  in_d[i] = 1'b0;
            end
        end
    end

    assign rise_ev = in_d & ~in_q & ren_q;
    assign fall_ev = ~in_d & in_q & fen_q;
    assign stat_d  = (stat_q & ~stat_clr) | rise_ev | fall_ev;
    assign irq_d   = |stat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            oe_q   <= '0;
            ren_q  <= '0;
            fen_q  <= '0;
            stat_q <= '0;
            in_q   <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            rdt_q  <= '0;
            err_q  <= 1'b0;
            irq_q  <= 1'b0;
            for (int unsigned i = 0; i < GW; i++) hist_q[i] <= '0;
        end else begin
            out_q  <= out_d;
            oe_q   <= oe_d;
            ren_q  <= ren_d;
            fen_q  <= fen_d;
            stat_q <= stat_d;
            in_q   <= in_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            rdt_q  <= rdt_d;
            err_q  <= err_d;
            irq_q  <= irq_d;
            for (int unsigned i = 0; i < GW; i++) hist_q[i] <= hist_d[i];
        end
    end

    assign bus_rdy = 1'b1;
    assign bus_rdt = rdt_q;
    assign bus_err = err_q;
    assign gpio_o  = out_q;
    assign gpio_e  = oe_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_r5p_gpio_ctrl.sv
// Directed bench for r5p_gpio_ctrl: register access, debounce timing, edge capture and errors.
module tb_r5p_gpio_ctrl;

    localparam logic [5:0] A_OUT  = 6'h00;
    localparam logic [5:0] A_OE   = 6'h04;
    localparam logic [5:0] A_IN   = 6'h08;
    localparam logic [5:0] A_SET  = 6'h0C;
    localparam logic [5:0] A_CLR  = 6'h10;
    localparam logic [5:0] A_RISE = 6'h14;
    localparam logic [5:0] A_FALL = 6'h18;
    localparam logic [5:0] A_STAT = 6'h1C;
    localparam logic [5:0] A_DIV  = 6'h20;

    logic        clk;
    logic        rst;
    logic        bus_vld;
    logic        bus_rdy;
    logic        bus_wen;
    logic [5:0]  bus_adr;
    logic [3:0]  bus_ben;
    logic [31:0] bus_wdt;
    logic [31:0] bus_rdt;
    logic        bus_err;
    logic [31:0] gpio_o;
    logic [31:0] gpio_e;
    logic [31:0] gpio_i;
    logic        irq;

    int tests;
    int fails;

    r5p_gpio_ctrl #(.GW(32), .AW(6), .DEB_N(3), .DIV_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus_vld (bus_vld),
        .bus_rdy (bus_rdy),
        .bus_wen (bus_wen),
        .bus_adr (bus_adr),
        .bus_ben (bus_ben),
        .bus_wdt (bus_wdt),
        .bus_rdt (bus_rdt),
        .bus_err (bus_err),
        .gpio_o  (gpio_o),
        .gpio_e  (gpio_e),
        .gpio_i  (gpio_i),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Called at a negedge: drive one transfer, return at the next negedge with the response.
    task automatic bus_wr(input logic [5:0] adr, input logic [31:0] d, input logic [3:0] ben,
                          output logic err);
        bus_vld = 1'b1; bus_wen = 1'b1; bus_adr = adr; bus_wdt = d; bus_ben = ben;
        @(negedge clk);
        err = bus_err;
        bus_vld = 1'b0; bus_wen = 1'b0;
    endtask

    task automatic bus_rd(input logic [5:0] adr, output logic [31:0] d, output logic err);
        bus_vld = 1'b1; bus_wen = 1'b0; bus_adr = adr; bus_wdt = '0; bus_ben = 4'h0;
        @(negedge clk);
        d = bus_rdt; err = bus_err;
        bus_vld = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        e;
        rst = 1'b1; gpio_i = '0;
        bus_vld = 1'b1; bus_wen = 1'b1; bus_adr = A_OUT; bus_wdt = 32'hFFFF_FFFF; bus_ben = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0; bus_vld = 1'b0; bus_wen = 1'b0;
        tests++;
        if (gpio_o !== 32'h0 || gpio_e !== 32'h0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: gpio_o=%h gpio_e=%h irq=%b, required 0/0/0", gpio_o, gpio_e, irq);
        end
        tests++;
        if (bus_rdt !== 32'h0 || bus_err !== 1'b0 || bus_rdy !== 1'b1) begin
            fails++;
            $display("FAIL reset_bus: rdt=%h err=%b rdy=%b, required 0/0/1", bus_rdt, bus_err, bus_rdy);
        end
        bus_rd(A_OUT, d, e);
        tests++;
        if (d !== 32'h0 || e !== 1'b0) begin
            fails++;
            $display("FAIL reset_read_out: rdt=%h err=%b, required 00000000/0", d, e);
        end
    endtask

    task automatic test_out_set_clr();
        logic [31:0] d;
        logic        e;
        bus_wr(A_OUT, 32'h0000_00F0, 4'hF, e);
        tests++;
        if (e !== 1'b0) begin
            fails++;
            $display("FAIL out_write_err: err=%b, required 0", e);
        end
        bus_wr(A_SET, 32'h0000_000F, 4'b0001, e);
        bus_wr(A_CLR, 32'h0000_0030, 4'b0001, e);
        bus_rd(A_OUT, d, e);
        tests++;
        if (d !== 32'h0000_00CF) begin
            fails++;
            $display("FAIL out_set_clr: rdt=%h, required 000000cf", d);
        end
        bus_wr(A_OUT, 32'hFFFF_FFFF, 4'b0010, e);
        bus_rd(A_OUT, d, e);
        tests++;
        if (d !== 32'h0000_FFCF || gpio_o !== 32'h0000_FFCF) begin
            fails++;
            $display("FAIL out_byte_mask: rdt=%h gpio_o=%h, required 0000ffcf", d, gpio_o);
        end
        bus_wr(A_SET, 32'hFFFF_0000, 4'b0011, e);
        bus_wr(A_CLR, 32'h0000_00FF, 4'b1110, e);
        tests++;
        if (gpio_o !== 32'h0000_FFCF) begin
            fails++;
            $display("FAIL set_clr_ben_masked: gpio_o=%h, required 0000ffcf", gpio_o);
        end
        bus_rd(A_SET, d, e);
        tests++;
        if (d !== 32'h0 || e !== 1'b0) begin
            fails++;
            $display("FAIL set_reads_zero: rdt=%h err=%b, required 0/0", d, e);
        end
        bus_wr(A_OE, 32'h1234_A5A5, 4'b0101, e);
        bus_rd(A_OE, d, e);
        tests++;
        if (d !== 32'h0034_00A5 || gpio_e !== 32'h0034_00A5) begin
            fails++;
            $display("FAIL oe_rw: rdt=%h gpio_e=%h, required 003400a5", d, gpio_e);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        logic        e;
        gpio_i[0] = 1'b1;
        repeat (2) @(negedge clk);
        bus_rd(A_IN, d, e);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL deb_not_yet: IN=%h, required 00000000", d);
        end
        bus_rd(A_IN, d, e);
        tests++;
        if (d !== 32'h1) begin
            fails++;
            $display("FAIL deb_accept: IN=%h, required 00000001", d);
        end
        gpio_i[1] = 1'b1;
        repeat (2) @(negedge clk);
        gpio_i[1] = 1'b0;
        repeat (5) @(negedge clk);
        bus_rd(A_IN, d, e);
        tests++;
        if (d !== 32'h1) begin
            fails++;
            $display("FAIL deb_glitch: IN=%h, required 00000001", d);
        end
    endtask

    task automatic test_edge_irq();
        logic [31:0] d;
        logic        e;
        bus_wr(A_RISE, 32'h1, 4'hF, e);
        bus_wr(A_FALL, 32'h2, 4'hF, e);
        gpio_i[1] = 1'b1;
        repeat (5) @(negedge clk);
        gpio_i[0] = 1'b0;
        repeat (5) @(negedge clk);
        bus_rd(A_STAT, d, e);
        tests++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL status_no_enabled_edge: STATUS=%h irq=%b, required 0/0", d, irq);
        end
        gpio_i[1:0] = 2'b01;
        repeat (3) @(negedge clk);
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_not_early: irq=%b, required 0", irq);
        end
        @(negedge clk);
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_assert: irq=%b, required 1", irq);
        end
        bus_rd(A_STAT, d, e);
        tests++;
        if (d !== 32'h3) begin
            fails++;
            $display("FAIL status_edges: STATUS=%h, required 00000003", d);
        end
        bus_wr(A_STAT, 32'h1, 4'h0, e);
        bus_rd(A_STAT, d, e);
        tests++;
        if (d !== 32'h3) begin
            fails++;
            $display("FAIL w1c_ben_zero: STATUS=%h, required 00000003", d);
        end
        bus_wr(A_STAT, 32'h1, 4'hF, e);
        bus_rd(A_STAT, d, e);
        tests++;
        if (d !== 32'h2 || irq !== 1'b1) begin
            fails++;
            $display("FAIL w1c_bit0: STATUS=%h irq=%b, required 00000002/1", d, irq);
        end
        bus_wr(A_STAT, 32'h2, 4'hF, e);
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_hold_one_cycle: irq=%b, required 1", irq);
        end
        @(negedge clk);
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_drop: irq=%b, required 0", irq);
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        logic        e;
        gpio_i[0] = 1'b0;
        repeat (5) @(negedge clk);
        gpio_i[0] = 1'b1;
        repeat (2) @(negedge clk);
        // This write lands on the same edge that IN[0] rises.
        bus_wr(A_STAT, 32'h1, 4'hF, e);
        bus_rd(A_STAT, d, e);
        tests++;
        if (d !== 32'h1) begin
            fails++;
            $display("FAIL w1c_set_wins: STATUS=%h, required 00000001", d);
        end
        bus_wr(A_STAT, 32'h1, 4'hF, e);
        bus_rd(A_STAT, d, e);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL w1c_after_collision: STATUS=%h, required 00000000", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        e;
        bus_rd(6'h24, d, e);
        tests++;
        if (d !== 32'h0 || e !== 1'b1) begin
            fails++;
            $display("FAIL unmapped_read: rdt=%h err=%b, required 00000000/1", d, e);
        end
        bus_wr(A_IN, 32'hFFFF_FFFF, 4'hF, e);
        tests++;
        if (e !== 1'b1 || bus_rdt !== 32'h0) begin
            fails++;
            $display("FAIL in_write_err: err=%b rdt=%h, required 1/00000000", e, bus_rdt);
        end
        bus_rd(A_IN, d, e);
        tests++;
        if (d !== 32'h1 || e !== 1'b0) begin
            fails++;
            $display("FAIL in_unchanged: IN=%h err=%b, required 00000001/0", d, e);
        end
        bus_wr(6'h3C, 32'hDEAD_BEEF, 4'hF, e);
        tests++;
        if (e !== 1'b1) begin
            fails++;
            $display("FAIL unmapped_write_err: err=%b, required 1", e);
        end
        bus_rd(A_OUT, d, e);
        tests++;
        if (d !== 32'h0000_FFCF || e !== 1'b0) begin
            fails++;
            $display("FAIL unmapped_write_ignored: OUT=%h err=%b, required 0000ffcf/0", d, e);
        end
    endtask

    task automatic test_prescaler();
        logic [31:0] d;
        logic        e;
        int          k;
        logic        got;
        bus_wr(A_DIV, 32'hFFFF_0004, 4'hF, e);
        bus_rd(A_DIV, d, e);
        tests++;
        if (d !== 32'h0000_0004) begin
            fails++;
            $display("FAIL div_readback: DEB_DIV=%h, required 00000004", d);
        end
        // Rewriting DEB_DIV zeroes the prescaler, so ticks fall on edges W+5, W+10, W+15.
        bus_wr(A_DIV, 32'h4, 4'hF, e);
        gpio_i[2] = 1'b1;
        k = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            k++;
            bus_rd(A_IN, d, e);
            if (d[2] === 1'b1) got = 1'b1;
        end
        tests++;
        if (!got || k != 16) begin
            fails++;
            $display("FAIL prescaled_latency: first IN[2]=1 on read %0d (seen=%b), required read 16", k, got);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus_vld = 1'b0; bus_wen = 1'b0; bus_adr = '0; bus_ben = '0; bus_wdt = '0;
        test_reset();
        test_out_set_clr();
        test_debounce();
        test_edge_irq();
        test_w1c_collision();
        test_errors();
        test_prescaler();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
